// File: rtl/alu_seq_unit_if.sv
// Start/Busy/Valid handshake bundle between the CPU control path and alu_seq_unit.
// The master side issues operations; the slave side is the ALU itself.
interface alu_seq_unit_if #(
   parameter int WIDTH = 16
);
   logic             Start;
   logic             Flush;
   logic [3:0]       AluCtrl;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] Dalja;
   logic             Zero;
   logic             Carry;
   logic             Overflow;
   logic             Busy;
   logic             Valid;

   modport master (
      output Start, Flush, AluCtrl, A, B,
      input  Dalja, Zero, Carry, Overflow, Busy, Valid
   );

   modport slave (
      input  Start, Flush, AluCtrl, A, B,
      output Dalja, Zero, Carry, Overflow, Busy, Valid
   );
endinterface

// File: rtl/alu_seq_unit.sv
// Registered WIDTH-bit ALU: single-cycle logic/arithmetic, bit-serial shifts and
// shift-add multiply behind a Start/Busy/Valid handshake.
module alu_seq_unit #(
   parameter int WIDTH = 16
) (
   input logic          Clock,
   input logic          Resetn,
   alu_seq_unit_if.slave bus
);
   localparam int SHW  = $clog2(WIDTH);
   localparam int CNTW = SHW + 1;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_SLT  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0101;
   localparam logic [3:0] OP_SLTU = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_MUL  = 4'b1011;

   localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0]  CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0]  CNT_MUL = CNTW'(WIDTH);

   typedef enum logic [1:0] {
      stIdle  = 2'b00,
      stShift = 2'b01,
      stMul   = 2'b10
   } state_t;

   state_t           stateR;
   logic [3:0]       opR;
   logic [WIDTH-1:0] workR;
   logic [WIDTH-1:0] mplierR;
   logic [WIDTH-1:0] accR;
   logic [CNTW-1:0]  countR;
   logic [WIDTH-1:0] daljaR;
   logic             zeroR;
   logic             carryR;
   logic             ovfR;
   logic             busyR;
   logic             validR;

   logic [WIDTH:0]   addSum;
   logic [WIDTH:0]   subSum;
   logic [SHW-1:0]   shAmt;
   logic             isShift;
   logic [WIDTH-1:0] quickRes;
   logic             quickCarry;
   logic             quickOvf;
   logic [WIDTH-1:0] shiftNext;
   logic [WIDTH-1:0] mulNext;

   // Subtraction goes through the adder as A + ~B + 1 so carry-out means no borrow.
   assign addSum  = {1'b0, bus.A} + {1'b0, bus.B};
   assign subSum  = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
   assign shAmt   = bus.B[SHW-1:0];
   assign isShift = (bus.AluCtrl == OP_SLL) || (bus.AluCtrl == OP_SRL) || (bus.AluCtrl == OP_SRA);

   // Single-cycle result and flags; shifts land here only when the amount is zero.
   always_comb begin
      quickRes   = '0;
      quickCarry = 1'b0;
      quickOvf   = 1'b0;
      case (bus.AluCtrl)
         OP_AND:  quickRes = bus.A & bus.B;
         OP_SLT:  quickRes = ($signed(bus.A) < $signed(bus.B)) ? ONE_W : '0;
         OP_OR:   quickRes = bus.A | bus.B;
         OP_XOR:  quickRes = bus.A ^ bus.B;
         OP_ADD: begin
            quickRes   = addSum[WIDTH-1:0];
            quickCarry = addSum[WIDTH];
            quickOvf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (addSum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SUB: begin
            quickRes   = subSum[WIDTH-1:0];
            quickCarry = subSum[WIDTH];
            quickOvf   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (subSum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SLTU: quickRes = (bus.A < bus.B) ? ONE_W : '0;
         OP_NOR:  quickRes = ~(bus.A | bus.B);
         OP_SLL, OP_SRL, OP_SRA: quickRes = bus.A;
         default: quickRes = '0;
      endcase
   end

   // One-bit shift step of the latched operand.
   always_comb begin
      shiftNext = workR;
      case (opR)
         OP_SLL:  shiftNext = {workR[WIDTH-2:0], 1'b0};
         OP_SRL:  shiftNext = {1'b0, workR[WIDTH-1:1]};
         OP_SRA:  shiftNext = {workR[WIDTH-1], workR[WIDTH-1:1]};
         default: shiftNext = workR;
      endcase
   end

   // Accumulator after folding in the current multiplier LSB.
   always_comb begin
      if (mplierR[0]) begin
         mulNext = accR + workR;
      end else begin
         mulNext = accR;
      end
   end

   // Sequencer FSM together with the registered result, flags and handshake.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         stateR  <= stIdle;
         opR     <= 4'b0000;
         workR   <= '0;
         mplierR <= '0;
         accR    <= '0;
         countR  <= '0;
         daljaR  <= '0;
         zeroR   <= 1'b0;
         carryR  <= 1'b0;
         ovfR    <= 1'b0;
         busyR   <= 1'b0;
         validR  <= 1'b0;
      end else begin
         validR <= 1'b0;
         case (stateR)
            stIdle: begin
               if (bus.Start) begin
                  opR <= bus.AluCtrl;
                  if (isShift && (shAmt != '0)) begin
                     workR  <= bus.A;
                     countR <= {1'b0, shAmt};
                     busyR  <= 1'b1;
                     stateR <= stShift;
                  end else if (bus.AluCtrl == OP_MUL) begin
                     workR   <= bus.A;
                     mplierR <= bus.B;
                     accR    <= '0;
                     countR  <= CNT_MUL;
                     busyR   <= 1'b1;
                     stateR  <= stMul;
                  end else begin
                     daljaR <= quickRes;
                     zeroR  <= (quickRes == '0);
                     carryR <= quickCarry;
                     ovfR   <= quickOvf;
                     validR <= 1'b1;
                  end
               end
            end
            stShift: begin
               // Flush beats completion: a cancelled op never reports.
               if (bus.Flush) begin
                  busyR  <= 1'b0;
                  stateR <= stIdle;
               end else if (countR == CNT_ONE) begin
                  daljaR <= shiftNext;
                  zeroR  <= (shiftNext == '0);
                  carryR <= 1'b0;
                  ovfR   <= 1'b0;
                  validR <= 1'b1;
                  busyR  <= 1'b0;
                  stateR <= stIdle;
               end else begin
                  workR  <= shiftNext;
                  countR <= countR - CNT_ONE;
               end
            end
            stMul: begin
               if (bus.Flush) begin
                  busyR  <= 1'b0;
                  stateR <= stIdle;
               end else if (countR == CNT_ONE) begin
                  daljaR <= mulNext;
                  zeroR  <= (mulNext == '0);
                  carryR <= 1'b0;
                  ovfR   <= 1'b0;
                  validR <= 1'b1;
                  busyR  <= 1'b0;
                  stateR <= stIdle;
               end else begin
                  accR    <= mulNext;
                  workR   <= {workR[WIDTH-2:0], 1'b0};
                  mplierR <= {1'b0, mplierR[WIDTH-1:1]};
                  countR  <= countR - CNT_ONE;
               end
            end
            default: begin
               busyR  <= 1'b0;
               stateR <= stIdle;
            end
         endcase
      end
   end

   assign bus.Dalja    = daljaR;
   assign bus.Zero     = zeroR;
   assign bus.Carry    = carryR;
   assign bus.Overflow = ovfR;
   assign bus.Busy     = busyR;
   assign bus.Valid    = validR;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed literal cases plus random traffic compared
// every cycle against an operation-level model (result + latency per op).
module tb_alu_seq_unit;
   localparam int W = 16;

   logic Clock;
   logic Resetn;
   int   checks = 0;
   int   errors = 0;

   alu_seq_unit_if #(.WIDTH(W)) bus ();

   alu_seq_unit #(.WIDTH(W)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct packed {
      logic [W-1:0] r;
      logic         c;
      logic         v;
      logic [7:0]   lat;
   } ref_t;

   // Operation-level reference: final value, flags and number of busy cycles.
   function automatic ref_t refOp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      ref_t             o;
      int               sa;
      int               sb;
      int               s;
      int               n;
      longint           prod;
      logic signed [W-1:0] sa16;
      logic [3:0]       amt;
      sa   = $signed(a);
      sb   = $signed(b);
      sa16 = a;
      amt  = b[3:0];
      n    = int'(amt);
      o    = '0;
      case (op)
         4'd0:  o.r = a & b;
         4'd1:  o.r = (sa < sb) ? 16'd1 : 16'd0;
         4'd2:  o.r = a | b;
         4'd3:  o.r = a ^ b;
         4'd4: begin
            o.r = a + b;
            o.c = ((int'(a) + int'(b)) > 65535);
            s   = sa + sb;
            o.v = (s > 32767) || (s < -32768);
         end
         4'd5: begin
            o.r = a - b;
            o.c = (a >= b);
            s   = sa - sb;
            o.v = (s > 32767) || (s < -32768);
         end
         4'd6:  o.r = (a < b) ? 16'd1 : 16'd0;
         4'd7:  o.r = ~(a | b);
         4'd8:  begin o.r = a << n;     o.lat = 8'(n); end
         4'd9:  begin o.r = a >> n;     o.lat = 8'(n); end
         4'd10: begin o.r = sa16 >>> n; o.lat = 8'(n); end
         4'd11: begin
            prod  = longint'(a) * longint'(b);
            o.r   = prod[15:0];
            o.lat = 8'(W);
         end
         default: o.r = 16'd0;
      endcase
      return o;
   endfunction

   ref_t cur;
   always_comb cur = refOp(bus.AluCtrl, bus.A, bus.B);

   logic [W-1:0] mDalja = '0;
   logic [W-1:0] pDalja = '0;
   logic mZero = 1'b0, mCarry = 1'b0, mOvf = 1'b0, mBusy = 1'b0, mValid = 1'b0;
   logic pCarry = 1'b0, pOvf = 1'b0;
   int   mRem = 0;

   // Expected outputs, advanced once per clock from the sampled inputs.
   always @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         mDalja <= '0; mZero <= 1'b0; mCarry <= 1'b0; mOvf <= 1'b0;
         mBusy  <= 1'b0; mValid <= 1'b0; mRem <= 0;
      end else begin
         mValid <= 1'b0;
         if (mBusy) begin
            if (bus.Flush) begin
               mBusy <= 1'b0;
            end else if (mRem == 1) begin
               mDalja <= pDalja; mZero <= (pDalja == 16'd0);
               mCarry <= pCarry; mOvf <= pOvf;
               mValid <= 1'b1; mBusy <= 1'b0;
            end else begin
               mRem <= mRem - 1;
            end
         end else if (bus.Start) begin
            if (cur.lat == 8'd0) begin
               mDalja <= cur.r; mZero <= (cur.r == 16'd0);
               mCarry <= cur.c; mOvf <= cur.v; mValid <= 1'b1;
            end else begin
               mBusy <= 1'b1; mRem <= int'(cur.lat);
               pDalja <= cur.r; pCarry <= cur.c; pOvf <= cur.v;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge Clock) begin
      check("Dalja",    32'(bus.Dalja),    32'(mDalja));
      check("Zero",     32'(bus.Zero),     32'(mZero));
      check("Carry",    32'(bus.Carry),    32'(mCarry));
      check("Overflow", 32'(bus.Overflow), 32'(mOvf));
      check("Busy",     32'(bus.Busy),     32'(mBusy));
      check("Valid",    32'(bus.Valid),    32'(mValid));
   end

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.AluCtrl = op; bus.A = a; bus.B = b; bus.Start = 1'b1;
      @(posedge Clock); #2;
      bus.Start = 1'b0;
   endtask

   task automatic waitValid(output int cyc);
      cyc = 0;
      while (bus.Valid !== 1'b1 && cyc < 200) begin
         @(posedge Clock); #2;
         cyc++;
      end
      if (bus.Valid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout actual=%0d cycles without Valid required=Valid", cyc);
      end
   endtask

   initial begin
      int cyc;
      bus.Start = 1'b0; bus.Flush = 1'b0; bus.AluCtrl = 4'd0; bus.A = '0; bus.B = '0;
      Resetn = 1'b1;
      #1 Resetn = 1'b0;
      #1;
      check("rst_dalja", 32'(bus.Dalja), 32'd0);
      check("rst_valid", 32'(bus.Valid), 32'd0);
      check("rst_busy",  32'(bus.Busy),  32'd0);
      check("rst_zero",  32'(bus.Zero),  32'd0);
      repeat (2) @(posedge Clock);
      #2 Resetn = 1'b1;
      @(posedge Clock); #2;

      // ADD overflow into the sign bit
      issue(4'd4, 16'h7FFF, 16'h0001);
      check("add_valid", 32'(bus.Valid), 32'd1);
      check("add_busy",  32'(bus.Busy),  32'd0);
      check("add_res",   32'(bus.Dalja), 32'h8000);
      check("add_ovf",   32'(bus.Overflow), 32'd1);
      check("add_carry", 32'(bus.Carry), 32'd0);
      check("add_zero",  32'(bus.Zero),  32'd0);

      // SUB to zero, then AND issued in the Valid cycle
      issue(4'd5, 16'h0005, 16'h0005);
      check("sub_res",   32'(bus.Dalja), 32'h0000);
      check("sub_zero",  32'(bus.Zero),  32'd1);
      check("sub_carry", 32'(bus.Carry), 32'd1);
      check("sub_ovf",   32'(bus.Overflow), 32'd0);
      issue(4'd0, 16'hF0F0, 16'h0FF0);
      check("and_valid", 32'(bus.Valid), 32'd1);
      check("and_res",   32'(bus.Dalja), 32'h00F0);
      check("and_carry", 32'(bus.Carry), 32'd0);

      // SRA by 3 with an ignored Start while busy
      issue(4'd10, 16'h8000, 16'h0003);
      check("sra_busy", 32'(bus.Busy), 32'd1);
      issue(4'd4, 16'h0001, 16'h0001);
      waitValid(cyc);
      check("sra_lat", 32'(cyc), 32'd2);
      check("sra_res", 32'(bus.Dalja), 32'hF000);
      @(posedge Clock); #2;
      check("sra_hold", 32'(bus.Dalja), 32'hF000);

      // Shift-add multiply
      issue(4'd11, 16'h0012, 16'h0034);
      waitValid(cyc);
      check("mul_lat", 32'(cyc), 32'd16);
      check("mul_res", 32'(bus.Dalja), 32'h03A8);
      issue(4'd11, 16'hFFFF, 16'h0002);
      waitValid(cyc);
      check("mul_wrap", 32'(bus.Dalja), 32'hFFFE);

      // Flush in cycle 5 of a multiply
      issue(4'd4, 16'h1200, 16'h0034);
      check("pre_flush", 32'(bus.Dalja), 32'h1234);
      issue(4'd11, 16'h0003, 16'h0004);
      repeat (4) begin @(posedge Clock); #2; end
      bus.Flush = 1'b1;
      @(posedge Clock); #2;
      bus.Flush = 1'b0;
      check("flush_busy",  32'(bus.Busy),  32'd0);
      check("flush_valid", 32'(bus.Valid), 32'd0);
      check("flush_res",   32'(bus.Dalja), 32'h1234);
      repeat (3) begin @(posedge Clock); #2; end
      issue(4'd1, 16'hFFFF, 16'h0001);
      check("slt_res", 32'(bus.Dalja), 32'h0001);
      issue(4'd6, 16'hFFFF, 16'h0001);
      check("sltu_res", 32'(bus.Dalja), 32'h0000);

      // Reset in the middle of a long SLL
      issue(4'd8, 16'h0001, 16'h000F);
      repeat (3) begin @(posedge Clock); #2; end
      Resetn = 1'b0;
      #1;
      check("mid_rst_busy",  32'(bus.Busy),  32'd0);
      check("mid_rst_dalja", 32'(bus.Dalja), 32'd0);
      check("mid_rst_zero",  32'(bus.Zero),  32'd0);
      repeat (2) @(posedge Clock);
      #2 Resetn = 1'b1;
      repeat (20) begin @(posedge Clock); #2; end
      check("post_rst_busy", 32'(bus.Busy), 32'd0);

      // Random traffic: short shift amounts are favoured so shifts finish often
      for (int i = 0; i < 3000; i++) begin
         bus.Start   = ($urandom_range(0, 2) == 0);
         bus.Flush   = ($urandom_range(0, 15) == 0);
         bus.AluCtrl = 4'($urandom_range(0, 15));
         bus.A       = 16'($urandom);
         bus.B       = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
         @(posedge Clock); #2;
      end
      bus.Start = 1'b0;
      bus.Flush = 1'b0;
      repeat (20) begin @(posedge Clock); #2; end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
Parametrised, registered successor to the 1-bit combinational ALU result select. Operates on WIDTH-bit operands and widens the op select to 4 bits. Single-cycle logic/arithmetic ops return in one clock. Multi-cycle shifts run one bit per clock and multiplication uses iterative shift-add. Sits between the register file read stage and writeback in the 16-bit CPU, using a Start/Busy/Valid handshake so control can stall on multi-cycle ops.

Parameters:
WIDTH, 16, operand/result width in bits; must be ≥4 and a power of two.
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
Clock  input  1  system clock, rising edge.
Resetn  input  1  asynchronous active-low reset.
Start  input  1  request; sampled only when Busy=0.
Flush  input  1  synchronous cancel of an in-flight multi-cycle op.
AluCtrl  input  4  operation select, latched at Start.
A  input  WIDTH  operand A, latched at Start.
B  input  WIDTH  operand B, latched at Start; B[SHW-1:0] is the shift amount.
Dalja  output  WIDTH  registered result.
Zero  output  1  registered; 1 when Dalja==0.
Carry  output  1  registered carry-out from ADD; no-borrow from SUB.
Overflow  output  1  registered signed overflow from ADD or SUB.
Busy  output  1  multi-cycle op in progress.
Valid  output  1  one-cycle pulse: Dalja and flags just updated.

Behaviour:
- Reset (Resetn=0, asynchronous): Dalja=0, Zero=0, Carry=0, Overflow=0, Busy=0, Valid=0, FSM=IDLE, internal count and work registers cleared. Applies immediately, including mid-operation. No Valid follows a reset.
- AluCtrl encoding:
  - 0000 AND
  - 0001 SLT (signed A<B → 1, else 0)
  - 0010 OR
  - 0011 XOR
  - 0100 ADD
  - 0101 SUB (A-B)
  - 0110 SLTU (unsigned)
  - 0111 NOR
  - 1000 SLL
  - 1001 SRL
  - 1010 SRA
  - 1011 MUL (low WIDTH bits of A*B)
  - 1100–1111 reserved: result 0, single-cycle.
- FSM states:
  - IDLE → SHIFT on Start with shift op and amount n≠0.
  - IDLE → MUL on Start with op 1011.
  - SHIFT/MUL → IDLE on completion or Flush.
- Single-cycle ops, and shifts with n=0: Start sampled at edge k. Result and flags load at edge k. Valid=1 for the cycle following edge k. Busy stays 0.
- Shift, n≥1:
  - Edge k: operand is captured, count=n, Busy→1.
  - Each following edge: shift one bit (SRA replicates the MSB) and decrement count.
  - Edge k+n: Dalja loads the result, Valid=1, Busy→0. Busy is high for exactly n cycles.
- MUL:
  - Edge k: multiplicand, multiplier, accumulator=0 and count=WIDTH are captured; Busy→1.
  - One multiplier bit is processed per edge.
  - Edge k+WIDTH: result loads, Valid=1, Busy→0.
- Start while Busy=1 is ignored; latched operands are unaffected.
- Back-to-back ops: Start may be asserted in the same cycle Valid is high; it is accepted because Busy=0.
- Flush:
  - With Busy=1, at the next edge go to IDLE with Busy=0 and no Valid; Dalja and flags are unchanged.
  - With Busy=0, Flush has no effect.
  - If Flush and Start are both high while Busy=0, Start is accepted.
- Flags:
  - Zero is updated with every Valid.
  - Carry and Overflow are updated only for ADD and SUB; they are cleared to 0 on Valid of any other op.
  - ADD: Carry is the bit WIDTH carry-out. Overflow=1 when A and B have the same sign and the result's sign differs.
  - SUB: computed as A+~B+1. Carry=1 means no borrow. Overflow=1 when A and B have different signs and the result's sign differs from A.
- Dalja and flags hold their values between Valid pulses.
- All arithmetic wraps modulo 2^WIDTH.

Test Plan:
- ADD, WIDTH=16, A=0x7FFF, B=0x0001 → Dalja=0x8000, Overflow=1, Carry=0, Zero=0; Valid one cycle after Start; Busy never high.
- SUB, A=0x0005, B=0x0005 → Dalja=0x0000, Zero=1, Carry=1, Overflow=0. A second op, AND with A=0xF0F0 and B=0x0FF0, issued in the Valid cycle → Dalja=0x00F0, Carry=0, Overflow=0.
- SRA, A=0x8000, B=0x0003 → Busy high 3 cycles, Valid after edge k+3, Dalja=0xF000. A Start during Busy (ADD with A=1, B=1) is ignored, and Dalja stays 0xF000.
- MUL, A=0x0012, B=0x0034 → Busy high 16 cycles, Valid after edge k+16, Dalja=0x03A8. Also A=0xFFFF, B=0x0002 → Dalja=0xFFFE.
- Flush at cycle 5 of MUL, starting with prior Dalja=0x1234 → Busy=0 after the next edge, no Valid, Dalja=0x1234. A subsequent SLT with A=0xFFFF, B=0x0001 → Dalja=0x0001; SLTU with the same operands → 0x0000.
- Resetn pulled low mid-SLL (A=0x0001, B=0x000F) → all outputs 0 immediately. After release, FSM is IDLE and no Valid appears.
